// File: rtl/matrix_pkg.sv
// Shared definitions for the packed matrix bus: geometry, element addressing and
// the result-streamer state encoding.
package matrix_pkg;

   localparam int unsigned MAX_DIM   = 5;
   localparam int unsigned ELEM_W    = 8;
   localparam int unsigned NUM_SLOTS = 2;
   localparam int unsigned SLOT_W    = MAX_DIM * MAX_DIM * ELEM_W;
   localparam int unsigned BUS_W     = NUM_SLOTS * SLOT_W;
   localparam int unsigned DIM_W     = 3;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } stream_state_e;

   // Bit offset of element (r,c) of a slot; the row stride is always MAX_DIM.
   function automatic int unsigned elem_offset(input int unsigned slot,
                                               input int unsigned r,
                                               input int unsigned c);
      return slot * SLOT_W + (r * MAX_DIM + c) * ELEM_W;
   endfunction

   function automatic logic dim_legal(input logic [DIM_W-1:0] d);
      return (d != '0) && (d <= DIM_W'(MAX_DIM));
   endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/col walker over an m x n region. Load resets to (0,0) and captures
// the bounds; each enable advances one column, wrapping into the next row.
module matrix_index_counter
   import matrix_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [DIM_W-1:0] i_m,
   input  logic [DIM_W-1:0] i_n,
   output logic [DIM_W-1:0] o_row,
   output logic [DIM_W-1:0] o_col,
   output logic             o_eol,
   output logic             o_last
);

   logic [DIM_W-1:0] r_row;
   logic [DIM_W-1:0] r_col;
   logic [DIM_W-1:0] r_m;
   logic [DIM_W-1:0] r_n;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row <= '0;
         r_col <= '0;
         r_m   <= '0;
         r_n   <= '0;
      end else if (i_load) begin
         r_row <= '0;
         r_col <= '0;
         r_m   <= i_m;
         r_n   <= i_n;
      end else if (i_en) begin
         if (o_eol) begin
            r_col <= '0;
            r_row <= o_last ? '0 : r_row + DIM_W'(1);
         end else begin
            r_col <= r_col + DIM_W'(1);
         end
      end
   end

   // Bounds are zero after reset, so eol/last stay low until the first load.
   assign o_eol  = (r_n != '0) && (r_col == r_n - DIM_W'(1));
   assign o_last = o_eol && (r_m != '0) && (r_row == r_m - DIM_W'(1));
   assign o_row  = r_row;
   assign o_col  = r_col;

endmodule

// File: rtl/matrix_result_streamer.sv
// Snapshots one matrix slot from the packed result bus and streams its elements
// in row-major order over valid/ready, tagged with row/col and framing flags.
module matrix_result_streamer
   import matrix_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_mat_sel,
   input  logic [DIM_W-1:0]  i_m,
   input  logic [DIM_W-1:0]  i_n,
   input  logic [BUS_W-1:0]  i_matrices_in,
   input  logic              i_src_valid,
   output logic              o_busy,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [ELEM_W-1:0] o_out_data,
   output logic [DIM_W-1:0]  o_out_row,
   output logic [DIM_W-1:0]  o_out_col,
   output logic              o_out_eol,
   output logic              o_out_last,
   output logic              o_done,
   output logic              o_err
);

   stream_state_e     r_state;
   logic              r_busy;
   logic              r_valid;
   logic              r_done;
   logic              r_err;
   logic [ELEM_W-1:0] r_snap [MAX_DIM][MAX_DIM];

   logic [ELEM_W-1:0] w_sel_elem [MAX_DIM][MAX_DIM];
   logic              w_accept;
   logic              w_load;
   logic              w_adv;
   logic [DIM_W-1:0]  w_row;
   logic [DIM_W-1:0]  w_col;
   logic              w_eol;
   logic              w_last;

   for (genvar gr = 0; gr < MAX_DIM; gr++) begin : g_row
      for (genvar gc = 0; gc < MAX_DIM; gc++) begin : g_col
         assign w_sel_elem[gr][gc] = i_mat_sel
                                     ? i_matrices_in[elem_offset(1, gr, gc) +: ELEM_W]
                                     : i_matrices_in[elem_offset(0, gr, gc) +: ELEM_W];
      end
   end

   assign w_accept = i_start && i_src_valid && dim_legal(i_m) && dim_legal(i_n);
   assign w_load   = (r_state == IDLE) && w_accept;
   assign w_adv    = (r_state == STREAM) && i_out_ready;

   matrix_index_counter u_index (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load),
      .i_en    (w_adv),
      .i_m     (i_m),
      .i_n     (i_n),
      .o_row   (w_row),
      .o_col   (w_col),
      .o_eol   (w_eol),
      .o_last  (w_last)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
               r_snap[r][c] <= '0;
            end
         end
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= STREAM;
                  r_busy  <= 1'b1;
                  r_valid <= 1'b1;
                  r_snap  <= w_sel_elem;
               end else if (i_start) begin
                  r_err <= 1'b1;
               end
            end
            STREAM: begin
               // Start requests are ignored here; only the handshake moves us on.
               if (i_out_ready && w_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   // Element and tags come straight from registered state; zeroed when not valid.
   assign o_out_data  = r_valid ? r_snap[w_row][w_col] : '0;
   assign o_out_row   = r_valid ? w_row : '0;
   assign o_out_col   = r_valid ? w_col : '0;
   assign o_out_eol   = r_valid && w_eol;
   assign o_out_last  = r_valid && w_last;
   assign o_out_valid = r_valid;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer: streams, stalls, rejected starts,
// snapshot isolation, 1x1 framing and asynchronous reset mid-stream.
module tb_matrix_result_streamer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         mat_sel;
   logic [2:0]   dm;
   logic [2:0]   dn;
   logic [399:0] matrices;
   logic         src_valid;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic [2:0]   out_row;
   logic [2:0]   out_col;
   logic         out_eol;
   logic         out_last;
   logic         done;
   logic         err;

   logic [7:0]   mat [2][5][5];
   int           n_vec = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   matrix_result_streamer dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_mat_sel     (mat_sel),
      .i_m           (dm),
      .i_n           (dn),
      .i_matrices_in (matrices),
      .i_src_valid   (src_valid),
      .o_busy        (busy),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready),
      .o_out_data    (out_data),
      .o_out_row     (out_row),
      .o_out_col     (out_col),
      .o_out_eol     (out_eol),
      .o_out_last    (out_last),
      .o_done        (done),
      .o_err         (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [399:0] pack_bus();
      logic [399:0] b = '0;
      for (int s = 0; s < 2; s++)
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               b[s*200 + (r*5 + c)*8 +: 8] = mat[s][r][c];
      return b;
   endfunction

   task automatic check_idle(input string tag);
      check_eq({tag, "_valid"}, out_valid, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_err"}, err, 0);
   endtask

   // Caller is at a negedge. stall: ready pattern 1,0,0 per cycle; zap: clear bus
   // mid-stream; dbl: hold start high through STREAM and DONE.
   task automatic run_stream(input int m, input int n, input int sel,
                             input bit stall, input bit zap, input bit dbl);
      logic [7:0] expv [25];
      int         idx;
      int         cyc;
      bit         rdy;
      for (int i = 0; i < m*n; i++) expv[i] = mat[sel][i/n][i%n];
      mat_sel   = sel[0];
      dm        = m[2:0];
      dn        = n[2:0];
      src_valid = 1'b1;
      out_ready = 1'b1;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = dbl;
      idx   = 0;
      cyc   = 1;
      while (idx < m*n && cyc < 300) begin
         rdy       = stall ? ((cyc - 1) % 3 == 0) : 1'b1;
         out_ready = rdy;
         check_eq("valid", out_valid, 1);
         check_eq("busy", busy, 1);
         check_eq("data", out_data, expv[idx]);
         check_eq("row", out_row, idx / n);
         check_eq("col", out_col, idx % n);
         check_eq("eol", out_eol, (idx % n) == n - 1);
         check_eq("last", out_last, idx == m*n - 1);
         check_eq("done_mid", done, 0);
         if (zap && idx == 5) matrices = '0;
         @(posedge clk);
         if (rdy) idx++;
         @(negedge clk);
         cyc++;
      end
      if (idx < m*n) check_eq("stream_timeout", idx, m*n);
      check_eq("done_pulse", done, 1);
      check_eq("done_busy", busy, 0);
      check_eq("done_valid", out_valid, 0);
      if (!stall) check_eq("start_to_done", cyc, m*n + 1);
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_idle("after_done");
      @(negedge clk);
      check_idle("after_done2");
   endtask

   task automatic err_case(input string tag, input int m, input int n, input bit sv);
      dm        = m[2:0];
      dn        = n[2:0];
      src_valid = sv;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_eq({tag, "_err"}, err, 1);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_valid"}, out_valid, 0);
      @(negedge clk);
      check_idle({tag, "_after"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      for (int s = 0; s < 2; s++)
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               mat[s][r][c] = 8'(s == 1 ? r*5 + c + 100 : 0);
      mat[0][0][0] = 8'd3;  mat[0][0][1] = 8'd6;  mat[0][0][2] = 8'd9;
      mat[0][1][0] = 8'd9;  mat[0][1][1] = 8'd12; mat[0][1][2] = 8'd15;

      rst_n     = 1'b0;
      start     = 1'b0;
      mat_sel   = 1'b0;
      dm        = 3'd0;
      dn        = 3'd0;
      src_valid = 1'b0;
      out_ready = 1'b0;
      matrices  = pack_bus();
      #1;
      check_idle("reset");
      check_eq("reset_data", out_data, 0);
      check_eq("reset_last", out_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      run_stream(2, 3, 0, 1'b0, 1'b0, 1'b0);
      run_stream(2, 3, 0, 1'b1, 1'b0, 1'b0);

      err_case("err_m0", 0, 3, 1'b1);
      err_case("err_n6", 2, 6, 1'b1);
      err_case("err_nosrc", 2, 3, 1'b0);

      run_stream(5, 5, 1, 1'b0, 1'b1, 1'b0);
      matrices = pack_bus();

      mat[0][0][0] = 8'hAB;
      matrices     = pack_bus();
      run_stream(1, 1, 0, 1'b0, 1'b0, 1'b1);

      // Abort a 5x5 stream after three handshakes.
      mat_sel   = 1'b1;
      dm        = 3'd5;
      dn        = 3'd5;
      src_valid = 1'b1;
      out_ready = 1'b1;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_eq("pre_abort_data", out_data, 100 + k);
         @(posedge clk);
         @(negedge clk);
      end
      check_eq("pre_abort_col", out_col, 3);
      #2 rst_n = 1'b0;
      #1;
      check_idle("abort");
      check_eq("abort_data", out_data, 0);
      check_eq("abort_row", out_row, 0);
      check_eq("abort_col", out_col, 0);
      check_eq("abort_eol", out_eol, 0);
      check_eq("abort_last", out_last, 0);
      @(negedge clk);
      check_idle("abort_held");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("abort_release");
      @(negedge clk);
      check_idle("abort_release2");
      run_stream(5, 5, 1, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
